// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver family.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5,
        WAIT_IDLE = 3'd6
    } uart_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Parity bit a transmitter would send for this word; unused upper bits must be 0.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] i_data,
                                         input int unsigned i_mode);
        logic w_xor;
        w_xor = ^i_data;
        return (i_mode == PAR_ODD) ? ~w_xor : w_xor;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Serial input conditioning: 2-flop synchroniser followed by a 3-sample majority voter.
module uart_rx_filter (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_RX_Serial,
    output logic o_Sync,
    output logic o_Voted
);

    logic       r_Sync1;
    logic       r_Sync2;
    logic [2:0] r_Window;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Sync1  <= 1'b1;
            r_Sync2  <= 1'b1;
            r_Window <= '1;
        end else begin
            r_Sync1  <= i_RX_Serial;
            r_Sync2  <= r_Sync1;
            r_Window <= {r_Window[1:0], r_Sync2};
        end
    end

    assign o_Sync  = r_Sync2;
    assign o_Voted = (r_Window[0] & r_Window[1]) |
                     (r_Window[0] & r_Window[2]) |
                     (r_Window[1] & r_Window[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with parity/framing error flags and line-break detection.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break
);

    import uart_pkg::*;

    localparam int unsigned MID = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    // START counts from the cycle after the edge was seen, hence MID-1.
    localparam logic [CW-1:0] START_LAST = CW'(MID - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

    logic                     w_Sync;
    logic                     w_Voted;
    logic                     w_Sample;
    logic                     w_Par_Err;
    logic                     w_Break;
    logic [MAX_DATA_BITS-1:0] w_Data_Ext;

    uart_state_t              r_State;
    logic [CW-1:0]            r_Clk_Cnt;
    logic [BW-1:0]            r_Bit_Cnt;
    logic [DATA_BITS-1:0]     r_Shift;
    logic                     r_Par_Bit;
    logic                     r_Stop1;
    logic                     r_Stop_Err;

    uart_rx_filter u_filter (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_RX_Serial (i_RX_Serial),
        .o_Sync      (w_Sync),
        .o_Voted     (w_Voted)
    );

    assign w_Sample = (r_Clk_Cnt == ((r_State == START) ? START_LAST : BIT_LAST));

    always_comb begin
        w_Data_Ext                = '0;
        w_Data_Ext[DATA_BITS-1:0] = r_Shift;
    end

    assign w_Par_Err = (PARITY != PAR_NONE) && (r_Par_Bit != calc_parity(w_Data_Ext, PARITY));
    assign w_Break   = (r_Shift == '0) && ((PARITY == PAR_NONE) || !r_Par_Bit) && !r_Stop1;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State      <= IDLE;
            r_Clk_Cnt    <= '0;
            r_Bit_Cnt    <= '0;
            r_Shift      <= '0;
            r_Par_Bit    <= 1'b0;
            r_Stop1      <= 1'b0;
            r_Stop_Err   <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            case (r_State)
                IDLE: begin
                    r_Clk_Cnt  <= '0;
                    r_Bit_Cnt  <= '0;
                    r_Stop_Err <= 1'b0;
                    if (!w_Sync) begin
                        r_State <= START;
                    end
                end

                START: begin
                    if (w_Sample) begin
                        r_Clk_Cnt <= '0;
                        r_State   <= w_Voted ? IDLE : DATA;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (w_Sample) begin
                        r_Clk_Cnt <= '0;
                        r_Shift   <= {w_Voted, r_Shift[DATA_BITS-1:1]};
                        if (r_Bit_Cnt == DATA_LAST) begin
                            r_Bit_Cnt <= '0;
                            r_State   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            r_Bit_Cnt <= r_Bit_Cnt + BW'(1);
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

                uart_pkg::PARITY: begin
                    if (w_Sample) begin
                        r_Clk_Cnt <= '0;
                        r_Par_Bit <= w_Voted;
                        r_State   <= STOP;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (w_Sample) begin
                        r_Clk_Cnt <= '0;
                        if (r_Bit_Cnt == '0) begin
                            r_Stop1 <= w_Voted;
                        end
                        if (!w_Voted) begin
                            r_Stop_Err <= 1'b1;
                        end
                        if (r_Bit_Cnt == STOP_LAST) begin
                            r_Bit_Cnt <= '0;
                            r_State   <= DONE;
                        end else begin
                            r_Bit_Cnt <= r_Bit_Cnt + BW'(1);
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

                DONE: begin
                    o_RX_DV      <= 1'b1;
                    o_RX_Data    <= r_Shift;
                    o_Parity_Err <= w_Par_Err;
                    o_Frame_Err  <= r_Stop_Err | w_Break;
                    o_Break      <= w_Break;
                    r_State      <= w_Voted ? IDLE : WAIT_IDLE;
                end

                // A held-low line must go high before a new start bit can be recognised.
                WAIT_IDLE: begin
                    if (w_Sync) begin
                        r_State <= IDLE;
                    end
                end

                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations, directed table,
// hand-written corner sequences and randomized frames against a frame-level model.
module tb_uart_rx_param;

    localparam int unsigned CPB = 16;
    localparam int unsigned MID = (CPB - 1) / 2;

    typedef struct {
        logic [8:0]  data;
        logic        pe;
        logic        fe;
        logic        br;
        int unsigned cyc;
    } rx_t;

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic [8:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_br;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx0, rx1, rx2;
    logic dv0, dv1, dv2;
    logic pe0, pe1, pe2;
    logic fe0, fe1, fe2;
    logic br0, br1, br2;
    logic [7:0] d0, d1;
    logic [8:0] d2;

    int unsigned cyc = 0;
    int unsigned t_fall = 0;
    int unsigned last_cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    rx_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8N1
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx0), .o_RX_DV(dv0), .o_RX_Data(d0),
        .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Break(br0));
    // 8E1
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx1), .o_RX_DV(dv1), .o_RX_Data(d1),
        .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(br1));
    // 9O2
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx2), .o_RX_DV(dv2), .o_RX_Data(d2),
        .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(br2));

    always @(negedge clk) if (dv0 === 1'b1) q0.push_back('{{1'b0, d0}, pe0, fe0, br0, cyc});
    always @(negedge clk) if (dv1 === 1'b1) q1.push_back('{{1'b0, d1}, pe1, fe1, br1, cyc});
    always @(negedge clk) if (dv2 === 1'b1) q2.push_back('{d2, pe2, fe2, br2, cyc});

    function automatic int unsigned db(input int d);
        return (d == 2) ? 9 : 8;
    endfunction

    function automatic int unsigned par(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic int unsigned stops(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic lvl, input int unsigned n);
        case (d)
            0:       rx0 = lvl;
            1:       rx1 = lvl;
            default: rx2 = lvl;
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                              input logic s1, input logic s2);
        t_fall = cyc;
        drive(d, 1'b0, CPB);
        for (int i = 0; i < int'(db(d)); i++) drive(d, data[i], CPB);
        if (par(d) != 0) drive(d, pbit, CPB);
        drive(d, s1, CPB);
        if (stops(d) == 2) drive(d, s2, CPB);
        drive(d, 1'b1, 3 * CPB);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : ((d == 1) ? q1.size() : q2.size());
    endfunction

    task automatic expect_frame(input int d, input string name, input logic [8:0] ed,
                                input logic epe, input logic efe, input logic ebr);
        rx_t r;
        int  n;
        n = qsize(d);
        check({name, " dv count"}, n, 1);
        if (n > 0) begin
            case (d)
                0:       r = q0.pop_front();
                1:       r = q1.pop_front();
                default: r = q2.pop_front();
            endcase
            check({name, " data"}, r.data, ed);
            check({name, " parity_err"}, r.pe, epe);
            check({name, " frame_err"}, r.fe, efe);
            check({name, " break"}, r.br, ebr);
            last_cyc = r.cyc;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Frame-level rules: word, parity rule, stop-bit rule, break rule.
    task automatic model(input int d, input logic [8:0] data, input logic pbit, input logic s1,
                         input logic s2, output logic [8:0] ed, output logic epe,
                         output logic efe, output logic ebr);
        int unsigned ones;
        int unsigned m;
        ones = 0;
        m    = par(d);
        ed   = '0;
        for (int i = 0; i < int'(db(d)); i++) begin
            ed[i] = data[i];
            ones += data[i];
        end
        epe = (m == 0) ? 1'b0 : (((ones + pbit) % 2) != ((m == 1) ? 1 : 0));
        ebr = (ed == 0) && (m == 0 || !pbit) && !s1;
        efe = !s1 || (stops(d) == 2 && !s2) || ebr;
    endtask

    vec_t        vecs[9];
    logic [8:0]  ed;
    logic        epe, efe, ebr;
    logic [8:0]  rdata;
    logic        rp, rs1, rs2;
    int          rd;

    initial begin
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h081, 1'b0, 1'b0, 1'b1, 9'h081, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 9'h055, 1'b0, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2, 9'h1FF, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2, 9'h1FF, 1'b1, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{2, 9'h000, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};

        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dv0", dv0, 0);
        check("reset data0", d0, 0);
        check("reset flags0", {pe0, fe0, br0}, 0);
        check("reset dv2", dv2, 0);
        check("reset data2", d2, 0);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * CPB);

        // 8N1 0xA5 with strobe timing: 2 sync flops + idle detect, MID, 8 data + 1 stop, +1.
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        expect_frame(0, "a5", 9'h0A5, 1'b0, 1'b0, 1'b0);
        check("a5 latency", last_cyc - t_fall, 3 + MID + 9 * CPB + 1);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].d, vecs[i].data, vecs[i].pbit, vecs[i].s1, vecs[i].s2);
            expect_frame(vecs[i].d, $sformatf("vec%0d", i), vecs[i].exp_data,
                         vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_br);
        end

        // Line held low for 12 bit times.
        drive(0, 1'b0, 12 * CPB);
        drive(0, 1'b1, 3 * CPB);
        expect_frame(0, "break", 9'h000, 1'b0, 1'b1, 1'b1);
        drive(0, 1'b1, 4 * CPB);
        check("break no second dv", qsize(0), 0);

        // Start pulse shorter than MID.
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 3 * CPB);
        check("short start no dv", qsize(0), 0);
        check("short start flags held", {fe0, br0}, 2'b11);

        // One-clock high glitch swept across the sample point of data bit 3 of 0x00.
        for (int off = 4 * CPB + 2; off <= 4 * CPB + 9; off++) begin
            drive(0, 1'b0, off);
            drive(0, 1'b1, 1);
            drive(0, 1'b0, 9 * CPB - off - 1);
            drive(0, 1'b1, 4 * CPB);
            expect_frame(0, $sformatf("glitch@%0d", off), 9'h000, 1'b0, 1'b0, 1'b0);
        end

        // 9O2 0x1FF, then a reset in the middle of DATA.
        send_frame(2, 9'h1FF, 1'b0, 1'b1, 1'b1);
        expect_frame(2, "9o2 1ff", 9'h1FF, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, CPB);
        drive(2, 1'b1, 4 * CPB);
        rst_n = 1'b0;
        #1;
        check("mid reset dv2", dv2, 0);
        check("mid reset data2", d2, 0);
        check("mid reset flags2", {pe2, fe2, br2}, 0);
        drive(2, 1'b1, 2);
        rst_n = 1'b1;
        drive(2, 1'b1, 8 * CPB);
        check("mid reset no dv", qsize(2), 0);
        send_frame(2, 9'h0A5, 1'b1, 1'b1, 1'b1);
        model(2, 9'h0A5, 1'b1, 1'b1, 1'b1, ed, epe, efe, ebr);
        expect_frame(2, "after reset", ed, epe, efe, ebr);

        for (int k = 0; k < 30; k++) begin
            rd    = k % 3;
            rdata = 9'($urandom);
            rp    = 1'($urandom);
            rs1   = ($urandom_range(0, 5) != 0);
            rs2   = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 5) == 0) begin
                rdata = '0;
                rp    = 1'b0;
                rs1   = 1'b0;
            end
            model(rd, rdata, rp, rs1, rs2, ed, epe, efe, ebr);
            send_frame(rd, rdata, rp, rs1, rs2);
            expect_frame(rd, $sformatf("rand%0d d%0d %03h", k, rd, rdata), ed, epe, efe, ebr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver that replaces the fixed 8N1 receiver in the VGA_Controller design. It supports configurable data width, parity and stop-bit count. It adds an input synchroniser, 3-sample majority voting, parity and framing error flags, and line-break detection. It sits between the COM-port serial pin and the command/pixel-write logic that consumes received words.

Parameters:
CLKS_PER_BIT, 217, system clocks per bit (25 MHz / 115200); legal values >= 8.
DATA_BITS, 8, data bits per frame; legal values 5..9; sent LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
i_Clk  input  1  system clock; all logic is on the rising edge.
i_Rst_n  input  1  reset; asynchronous, active-low.
i_RX_Serial  input  1  asynchronous serial line; idles high.
o_RX_DV  output  1  one-cycle strobe: a frame has completed.
o_RX_Data  output  DATA_BITS  received word; valid from o_RX_DV and held until the next o_RX_DV.
o_Parity_Err  output  1  parity mismatch on the last frame; same validity as o_RX_Data; always 0 when PARITY = 0.
o_Frame_Err  output  1  any stop bit sampled 0 on the last frame; same validity as o_RX_Data.
o_Break  output  1  last frame was a break (see below); same validity as o_RX_Data.

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; all counters 0.
  - Synchroniser flops and the 3-sample window reset to 1.
  - o_RX_DV, o_Parity_Err, o_Frame_Err, o_Break = 0; o_RX_Data = 0.
  - Reset mid-frame abandons the frame immediately; no o_RX_DV is produced for it.
- Input path: 2-flop synchroniser, then a 3-bit shift window. The voted bit is the majority of the window, i.e. the last 3 synchronised samples.
- Sample point: MID = (CLKS_PER_BIT-1)/2 clocks after the start edge is seen in IDLE, then every CLKS_PER_BIT clocks after that. The voted bit is taken at each sample point.
- States:
  - IDLE: synchronised line == 0 -> START; clear bit counter and clock counter.
  - START: at MID, voted == 0 -> DATA; voted == 1 -> IDLE (false start, no strobe, flags unchanged).
  - DATA: shift voted bits in LSB first. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: capture the parity bit -> STOP.
  - STOP: sample STOP_BITS stop bits; set the frame-error flag if any of them samples 0. After the last stop sample -> DONE.
  - DONE: one cycle.
    - Assert o_RX_DV; update o_RX_Data and all three flags together.
    - Line voted 1 -> IDLE; voted 0 -> WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line == 1, then -> IDLE. This prevents a held-low line being treated as a new start.
- Latency: o_RX_DV rises on the clock after the last stop-bit sample point, i.e. mid-stop-bit rather than end-of-frame. This tolerates back-to-back frames with up to ~half-bit clock skew.
- Parity check:
  - Even mode: XOR of data bits and parity bit must be 0.
  - Odd mode: that XOR must be 1.
  - Any mismatch -> o_Parity_Err = 1.
- Break: all data bits, the parity bit (if present) and the first stop bit sampled 0 -> o_Break = 1 and o_Frame_Err = 1, with o_RX_Data = 0.
- Flags are registered alongside o_RX_Data and change only in DONE.
- Counter widths: clock counter $clog2(CLKS_PER_BIT); bit counter $clog2(DATA_BITS+1). No wrap occurs within a frame.
- Glitch filtering: a one-clock glitch at any sample point is rejected by the majority vote. A start pulse shorter than MID clocks produces no strobe.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
  - parity constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - function computing the expected parity bit.
- One sub-module, uart_rx_filter:
  - 2-flop synchroniser plus 3-sample majority voter.
  - Ports: i_Clk, i_Rst_n, i_RX_Serial, o_Sync, o_Voted.
  - Reused by the future uart_tx loopback checker.
- Top level: FSM, counters, shift register, output registers.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 -> exactly one o_RX_DV, o_RX_Data=0xA5, all flags 0, strobe 1 clock after the stop mid-sample.
- PARITY=2, send 0x3C with parity bit 1 (wrong) -> DV, data 0x3C, o_Parity_Err=1. Resend with parity bit 0 -> o_Parity_Err=0.
- 8N1, send 0x81 with stop bit 0, then line high -> DV, data 0x81, o_Frame_Err=1, o_Break=0, next frame decodes normally.
- Line low for 12 bit times, then high -> single DV, data 0x00, o_Frame_Err=1, o_Break=1; no second DV until a new valid start bit.
- Start pulse low for 5 clocks; then a 1-clock high glitch at a data-bit sample point of 0x00 -> first gives no DV; second gives DV, data 0x00, no errors.
- DATA_BITS=9, STOP_BITS=2, send 0x1FF; also assert i_Rst_n low mid-DATA -> normal case gives DV with 0x1FF; reset case gives outputs 0 immediately, no DV, next frame correct.
